// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_pcore transmitter/receiver pair.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Callers zero-extend narrower words, so the upper bits do not disturb the XOR.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input parity_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_pcore_if.sv
// Byte-side handshake and serial pins of uart_pcore bundled as one interface.
interface uart_pcore_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_valid, rx,
        input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx,
        output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: mid pulse at period/2, end pulse at period, wraps on end.
module uart_bit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_mid,
    output logic             o_end
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_half;

    assign w_last = i_period - CNT_W'(1);
    assign w_half = (i_period >> 1) - CNT_W'(1);
    assign o_end  = (r_cnt == w_last);
    assign o_mid  = (r_cnt == w_half);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_pcore.sv
// Full-duplex UART core with configurable frame format; TX and RX share only the clock.
module uart_pcore
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    uart_pcore_if.slave  bus
);
    localparam int               BIT_CYC   = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W     = $clog2(BIT_CYC) + 1;
    localparam logic [CNT_W-1:0] PERIOD    = CNT_W'(BIT_CYC);
    localparam parity_e          PAR_MODE  = parity_e'(2'(PARITY));
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_TX_IDLE   = TX_IDLE;
    localparam logic [2:0] S_TX_START  = TX_START;
    localparam logic [2:0] S_TX_DATA   = TX_DATA;
    localparam logic [2:0] S_TX_PARITY = TX_PARITY;
    localparam logic [2:0] S_TX_STOP   = TX_STOP;
    localparam logic [2:0] S_RX_IDLE   = RX_IDLE;
    localparam logic [2:0] S_RX_START  = RX_START;
    localparam logic [2:0] S_RX_DATA   = RX_DATA;
    localparam logic [2:0] S_RX_PARITY = RX_PARITY;
    localparam logic [2:0] S_RX_STOP   = RX_STOP;
    localparam logic [2:0] S_RX_BREAK  = RX_BREAK;

    if (BIT_CYC < 4) begin : g_chk_baud
        $error("uart_pcore: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_pcore: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_pcore: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_pcore: STOP_BITS must be 1 or 2");
    end

    logic                 r_tx_ready;
    logic                 r_tx;
    logic [2:0]           r_tx_state;
    logic [3:0]           r_tx_bitcnt;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 w_tx_mid;
    logic                 w_tx_end;
    logic                 w_tx_last_stop;
    logic                 w_tx_accept;

    // A held tx_valid is taken on the edge that ends the last stop bit, chaining frames gap-free.
    assign w_tx_last_stop = (r_tx_state == S_TX_STOP) && w_tx_end && (r_tx_stop == LAST_STOP);
    assign w_tx_accept    = bus.tx_valid && (r_tx_ready || w_tx_last_stop);

    uart_bit_timer #(.CNT_W(CNT_W)) u_tx_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_tx_accept),
        .i_period  (PERIOD),
        .o_mid     (w_tx_mid),
        .o_end     (w_tx_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= S_TX_IDLE;
            r_tx_ready  <= 1'b1;
            r_tx        <= 1'b1;
            r_tx_bitcnt <= '0;
            r_tx_stop   <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_state <= S_TX_START;
            r_tx_ready <= 1'b0;
            r_tx       <= 1'b0;
        end else if (w_tx_end) begin
            case (r_tx_state)
                S_TX_START: begin
                    r_tx        <= r_tx_shift[0];
                    r_tx_bitcnt <= '0;
                    r_tx_state  <= S_TX_DATA;
                end
                S_TX_DATA: begin
                    if (r_tx_bitcnt == LAST_BIT) begin
                        if (PAR_MODE != PAR_NONE) begin
                            r_tx       <= r_tx_par;
                            r_tx_state <= S_TX_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_tx_stop  <= 1'b0;
                            r_tx_state <= S_TX_STOP;
                        end
                    end else begin
                        r_tx        <= r_tx_shift[1];
                        r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
                    end
                end
                S_TX_PARITY: begin
                    r_tx       <= 1'b1;
                    r_tx_stop  <= 1'b0;
                    r_tx_state <= S_TX_STOP;
                end
                S_TX_STOP: begin
                    if (r_tx_stop == LAST_STOP) begin
                        r_tx_ready <= 1'b1;
                        r_tx_state <= S_TX_IDLE;
                    end else begin
                        r_tx_stop <= 1'b1;
                    end
                end
                default: r_tx_state <= S_TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_accept) begin
            r_tx_shift <= bus.tx_data;
            r_tx_par   <= parity_of(MAX_DATA_BITS'(bus.tx_data), PAR_MODE);
        end else if (r_tx_state == S_TX_DATA && w_tx_end) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.tx       = r_tx;

    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic                 r_rxs_d;
    logic [2:0]           r_rx_state;
    logic [3:0]           r_rx_bitcnt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_parbit;
    logic                 w_rxs;
    logic                 w_rx_restart;
    logic                 w_rx_mid;
    logic                 w_rx_end;

    assign w_rxs        = r_rx_s2;
    assign w_rx_restart = (r_rx_state == S_RX_IDLE) && r_rxs_d && !w_rxs;

    uart_bit_timer #(.CNT_W(CNT_W)) u_rx_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_rx_restart),
        .i_period  (PERIOD),
        .o_mid     (w_rx_mid),
        .o_end     (w_rx_end)
    );

    logic w_unused_pulses;
    assign w_unused_pulses = &{1'b0, w_tx_mid, w_rx_end};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rxs_d     <= 1'b1;
            r_rx_state  <= S_RX_IDLE;
            r_rx_bitcnt <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_rx_ferr   <= 1'b0;
        end else begin
            r_rx_s1    <= bus.rx;
            r_rx_s2    <= r_rx_s1;
            r_rxs_d    <= w_rxs;
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                S_RX_IDLE: begin
                    if (w_rx_restart) r_rx_state <= S_RX_START;
                end
                S_RX_START: begin
                    if (w_rx_mid) begin
                        r_rx_bitcnt <= '0;
                        r_rx_state  <= w_rxs ? S_RX_IDLE : S_RX_DATA;
                    end
                end
                S_RX_DATA: begin
                    if (w_rx_mid) begin
                        if (r_rx_bitcnt == LAST_BIT) begin
                            r_rx_state <= (PAR_MODE != PAR_NONE) ? S_RX_PARITY : S_RX_STOP;
                        end else begin
                            r_rx_bitcnt <= r_rx_bitcnt + 4'd1;
                        end
                    end
                end
                S_RX_PARITY: begin
                    if (w_rx_mid) r_rx_state <= S_RX_STOP;
                end
                S_RX_STOP: begin
                    if (w_rx_mid) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_rx_perr  <= (PAR_MODE != PAR_NONE) &&
                                      (r_rx_parbit != parity_of(MAX_DATA_BITS'(r_rx_shift), PAR_MODE));
                        r_rx_ferr  <= !w_rxs;
                        r_rx_state <= w_rxs ? S_RX_IDLE : S_RX_BREAK;
                    end
                end
                // Hold here while the line stays low so a break yields a single frame.
                S_RX_BREAK: begin
                    if (w_rxs) r_rx_state <= S_RX_IDLE;
                end
                default: r_rx_state <= S_RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_rx_state == S_RX_DATA && w_rx_mid) begin
            r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
        end
        if (r_rx_state == S_RX_PARITY && w_rx_mid) begin
            r_rx_parbit <= w_rxs;
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
endmodule

// File: doc/uart_pcore.md
# uart_pcore

Parametrised full-duplex UART core: a configurable-frame transmitter and receiver sharing one clock. Supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. The transmitter has a valid/ready handshake. The receiver has a synchronised input, mid-bit sampling, false-start rejection, and parity/framing error reporting. It sits between the serial pins and any byte-level client (FIFO, register bank, bus bridge), and it succeeds the fixed 8N1 uart_top pair.

## Interface
- CLK_FREQ, 1000000: clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- tx_data  in  DATA_BITS  word to send; sampled on acceptance.
- tx_valid  in  1  client has a word.
- tx_ready  out  1  core can accept; reset 1.
- tx  out  1  serial output; reset 1 (idle/mark).
- rx  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received word; reset 0; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse per completed frame; reset 0.
- rx_parity_err  out  1  parity mismatch for the frame flagged by rx_valid; reset 0; valid with rx_valid.
- rx_frame_err  out  1  first stop bit sampled 0; reset 0; valid with rx_valid.

## Operation
- BIT_CYC = CLK_FREQ/BAUD_RATE, integer division, computed at elaboration. Elaboration fails if BIT_CYC < 4, DATA_BITS is outside 5..9, PARITY > 2, or STOP_BITS is not 1 or 2.
- Frame order: start (0), data LSB first, optional parity, stop (1) ×STOP_BITS.
- Parity: even → parity bit = XOR of the data bits; odd → its inverse.
- TX FSM: TX_IDLE → TX_START → TX_DATA → TX_PARITY (skipped when PARITY = 0) → TX_STOP → TX_IDLE.
  - Acceptance occurs on an edge where tx_valid && tx_ready. At that edge: tx_data is latched, tx goes to 0, tx_ready goes to 0, and the bit timer restarts.
  - Every bit lasts exactly BIT_CYC clk cycles.
  - tx_ready rises on the edge that ends the last stop bit. If tx_valid is high at that edge, the next frame is accepted on that edge, so no idle gap appears on the line.
  - tx_valid is ignored while tx_ready = 0. tx_data changes during a frame have no effect.
- RX input: rx passes through a 2-flop synchroniser, reset value 1. All RX logic uses the synchronised signal rxs.
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_PARITY (skipped when PARITY = 0) → RX_STOP → RX_IDLE. An additional state, RX_BREAK, is described below.
  - RX_IDLE: a 1→0 transition on rxs restarts the bit timer.
  - RX_START: rxs is sampled at BIT_CYC/2. If the sample is 1, the edge was a false start: go to RX_IDLE with no output.
  - Each subsequent bit is sampled BIT_CYC cycles after the previous sample. Data is shifted in LSB first.
  - RX_STOP: only the first stop bit is sampled. On the sample edge, rx_data is updated, rx_valid pulses for one cycle, and both error flags are registered.
  - If the stop sample is 1, go to RX_IDLE.
  - If the stop sample is 0 (framing error or break), go to RX_BREAK. RX_BREAK waits for rxs = 1 before returning to RX_IDLE, so a held-low line yields exactly one rx_valid.
- Error flags are recomputed on every frame and are not sticky.
- rx_valid has no back-pressure. A client that misses it loses the word.
- Asserting rst at any point, including mid-frame, returns both FSMs to idle immediately and sets all outputs to their reset values. No partial frame is emitted on either side.

## Timing
- TX line length per frame = (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × BIT_CYC cycles, measured from the accept edge to the tx_ready rising edge.
- RX: rx_valid pulses 2 + BIT_CYC/2 + (DATA_BITS + (PARITY ≠ 0) + 1) × BIT_CYC cycles after rx falls, ±1 cycle for synchroniser phase.
- Full duplex: TX and RX are fully independent, with no shared state.
- Receiver tolerance: at least ±4% baud mismatch, given mid-bit sampling.

## Structure
- Shared package uart_pkg holds the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD), the tx_state_e and rx_state_e enums, and the parity function.
- Sub-module uart_bit_timer, instantiated twice (TX and RX):
  - Inputs: restart, period.
  - Outputs: mid pulse at period/2, end pulse at period.
  - Counter width: $clog2(BIT_CYC) + 1 bits.
  - It is free-running after restart and wraps on its end pulse.

## Test plan
- 8N1 defaults (BIT_CYC = 104), tx looped back to rx, send 0xA5 → tx low for 104 cycles, then bits 1,0,1,0,0,1,0,1. tx_ready is low for 1040 cycles. rx_valid fires once with rx_data = 0xA5 and both error flags 0.
- PARITY = 1: send 0x03, expect parity bit 0. Then drive a frame with the parity bit inverted → rx_valid with rx_parity_err = 1 and rx_data = 0x03.
- DATA_BITS = 7, PARITY = 2, STOP_BITS = 2: send 0x7F and 0x00 back to back (tx_valid held) → frame length 11 × 104 cycles each, no gap between frames, odd parity bits 0 then 1, two rx_valid pulses.
- False start: hold rx low for 20 cycles, then high → no rx_valid, and the FSM is back in RX_IDLE. A valid frame sent afterwards is received correctly.
- Break: hold rx low for 30 bit periods → exactly one rx_valid with rx_frame_err = 1 and rx_data = 0. The next frame after rx returns high is received normally.
- Reset mid-frame: assert rst during data bit 3 of both TX and RX → tx = 1 and tx_ready = 1 immediately, no rx_valid. After rst is released, a new 0x5A transfer completes correctly.
